stage_4_mem: RTL and testbench
==============================

STAGE_4_MEM -- requirements
Module: stage_4_mem

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  pipeline clock (Clock); all state updates on falling edge, matching the other pipeline-stage registers
- rst_n  in  1  asynchronous, active-low reset
- alu_res  in  32  execute-stage result; the memory address for load/store
- rs2_val  in  32  store data
- rd_idx  in  5  destination register
- mem_load_enable  in  1  instruction is a load
- mem_store_enable  in  1  instruction is a store
- reg_write_enable  in  1  instruction writes rd
- dmem_req  out  1  data-memory request, registered
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word address, equal to alu_res latched at issue
- dmem_wdata  out  32  store data latched at issue
- dmem_rdata  in  32  read data, valid when dmem_ack = 1
- dmem_ack  in  1  completion strobe, sampled on the falling edge
- stall_out  out  1  hold all upstream stages
- wb_val_out  out  32  writeback value, registered
- rd_idx_out  out  5  writeback register, registered
- reg_write_enable_out  out  1  writeback enable, registered
- fault_out  out  1  misaligned access flag, registered; present only with the macro in REQ-017

Function
REQ-002 The block SHALL implement a three-state FSM: IDLE, REQ, DONE.
REQ-003 Define mem_op = mem_load_enable | mem_store_enable; if both are set, the block SHALL treat the access as a load and ignore the store.
REQ-004 IDLE with mem_op = 0: on the next edge the block SHALL register wb_val_out <= alu_res, rd_idx_out <= rd_idx and reg_write_enable_out <= reg_write_enable, giving 1-edge latency; the FSM stays in IDLE.
REQ-005 IDLE with mem_op = 1: stall_out SHALL be high combinationally. On the next edge the block SHALL set dmem_req = 1, latch dmem_addr, dmem_wdata and dmem_we, set reg_write_enable_out = 0 (bubble), and go to REQ.
REQ-006 In REQ, stall_out SHALL stay 1, and dmem_req, dmem_addr, dmem_wdata and dmem_we SHALL stay stable until dmem_ack is sampled high.
REQ-007 When dmem_ack = 1 is sampled in REQ, the block SHALL:
- drop dmem_req;
- for a load, register wb_val_out <= dmem_rdata, rd_idx_out <= rd_idx and reg_write_enable_out <= reg_write_enable;
- for a store, set reg_write_enable_out <= 0;
- go to DONE.
REQ-008 In DONE, stall_out SHALL be 0 so upstream advances on that edge. On that edge the block SHALL set reg_write_enable_out <= 0 and go to IDLE, and SHALL NOT re-issue the completed access.
REQ-009 The block SHALL ignore dmem_ack outside REQ.
REQ-010 Every edge on which a writeback is not produced SHALL drive reg_write_enable_out = 0; wb_val_out and rd_idx_out hold their values.
REQ-011 With zero wait states (ack sampled on the first REQ edge), a load SHALL occupy 3 edges, stall upstream for 2 cycles, and produce writeback at the 2nd edge.
REQ-012 The number of wait states SHALL be unbounded; the block SHALL have no timeout.

Reset
REQ-013 While rst_n = 0, the block SHALL immediately force the FSM to IDLE and drive all registered outputs to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_val_out, rd_idx_out, reg_write_enable_out and fault_out.
REQ-014 On reset assertion mid-transaction (REQ), the block SHALL drop dmem_req asynchronously and discard the access; a late dmem_ack after reset release SHALL be ignored.
REQ-015 stall_out SHALL be 0 during reset.
REQ-016 The first edge after rst_n rises SHALL be treated as IDLE.

Configuration
REQ-017 Macro STAGE4_MEM_ALIGN_CHECK_EN:
- defined: a mem_op in IDLE with alu_res[1:0] != 0 issues no request, stays in IDLE with no stall, and for 1 edge registers fault_out = 1 and reg_write_enable_out = 0;
- undefined: alignment is not checked, the fault_out port is absent, and the address is issued as given.

Verification
REQ-018 Directed scenario: a non-mem op with alu_res = 0x00000055, rd_idx = 7 and reg_write_enable = 1 SHALL give wb_val_out = 0x55, rd_idx_out = 7 and reg_write_enable_out = 1 after 1 edge, with stall_out = 0 throughout.
REQ-019 Directed scenario: a load with addr 0x100, ack on the first REQ edge and rdata 0xDEADBEEF SHALL give dmem_req high for 1 edge, stall_out high for 2 cycles and wb_val_out = 0xDEADBEEF with write enable pulsed for 1 edge.
REQ-020 Directed scenario: a store with addr 0x200, data 0x12345678 and ack delayed 3 edges SHALL give dmem_we = 1 and addr/wdata stable for 3 edges, stall held, and reg_write_enable_out = 0 throughout.
REQ-021 Directed scenario: rst_n pulsed low while in REQ SHALL drop dmem_req immediately, and an ack arriving 1 edge after release SHALL produce no writeback.
REQ-022 Directed scenario: back-to-back loads SHALL each be issued exactly once, giving two dmem_req pulses and no duplicate writeback.
REQ-023 Directed scenario (macro defined): a load at addr 0x102 SHALL give fault_out = 1 for 1 edge, with no dmem_req and no stall.

Source files
------------

// File: rtl/stage_4_mem.sv
// stage_4_mem: memory-access pipeline stage.
// Non-memory instructions pass their ALU result to writeback with one edge of
// latency. Loads and stores issue a single request to data memory, stall the
// upstream stages until the memory acknowledges, then release for one cycle.
// All state advances on the falling edge of clk, like the other pipeline registers.
// Optional feature: define STAGE4_MEM_ALIGN_CHECK_EN to reject misaligned word
// accesses and report them on fault_out. The fault_out port exists only in that build.
module stage_4_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_idx,
  input  logic        mem_load_enable,
  input  logic        mem_store_enable,
  input  logic        reg_write_enable,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic [31:0] wb_val_out,
  output logic [4:0]  rd_idx_out,
  output logic        reg_write_enable_out
`ifdef STAGE4_MEM_ALIGN_CHECK_EN
  ,
  output logic        fault_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic mem_op;
  logic is_store;
  logic misaligned;
  logic issue;

  // A load takes priority when both enables are set, so only a pure store writes memory.
  assign mem_op   = mem_load_enable | mem_store_enable;
  assign is_store = mem_store_enable & ~mem_load_enable;

`ifdef STAGE4_MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op & (alu_res[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A new access starts only from IDLE. DONE never issues, so the instruction that
  // is still presented during DONE is not sent to memory a second time.
  assign issue = (state == IDLE) & mem_op & ~misaligned;

  // State register; reset abandons any outstanding access.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. REQ has no timeout and waits as long as the memory needs.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (issue) begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Stall upstream while an access is being issued or is outstanding, and never during reset.
  always_comb begin
    stall_out = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    stall_out = mem_op & ~misaligned;
        REQ:     stall_out = 1'b1;
        default: stall_out = 1'b0;
      endcase
    end
  end

  // Memory-request and writeback registers. The writeback enable defaults to a bubble every edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= 32'h0;
      dmem_wdata           <= 32'h0;
      wb_val_out           <= 32'h0;
      rd_idx_out           <= 5'd0;
      reg_write_enable_out <= 1'b0;
    end else begin
      reg_write_enable_out <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= alu_res;
            dmem_wdata <= rs2_val;
          end else if (!mem_op) begin
            wb_val_out           <= alu_res;
            rd_idx_out           <= rd_idx;
            reg_write_enable_out <= reg_write_enable;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              wb_val_out           <= dmem_rdata;
              rd_idx_out           <= rd_idx;
              reg_write_enable_out <= reg_write_enable;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef STAGE4_MEM_ALIGN_CHECK_EN
  // Misalignment flag, raised for exactly one edge when a misaligned access is rejected.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_out <= 1'b0;
    end else begin
      fault_out <= (state == IDLE) & misaligned;
    end
  end
`endif

endmodule

// File: tb/tb_stage_4_mem.sv
// tb_stage_4_mem: directed self-checking bench for stage_4_mem.
// The DUT updates on the falling clock edge; outputs are sampled 1 time unit after
// that edge, and inputs are driven at the same point, well before the next edge.
// Build with STAGE4_MEM_ALIGN_CHECK_EN defined to exercise the fault_out path.
module tb_stage_4_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_res;
  logic [31:0] rs2_val;
  logic [4:0]  rd_idx;
  logic        mem_load_enable;
  logic        mem_store_enable;
  logic        reg_write_enable;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_out;
  logic [31:0] wb_val_out;
  logic [4:0]  rd_idx_out;
  logic        reg_write_enable_out;
`ifdef STAGE4_MEM_ALIGN_CHECK_EN
  logic        fault_out;
`endif

  int errors = 0;
  int checks = 0;

  stage_4_mem dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .alu_res              (alu_res),
    .rs2_val              (rs2_val),
    .rd_idx               (rd_idx),
    .mem_load_enable      (mem_load_enable),
    .mem_store_enable     (mem_store_enable),
    .reg_write_enable     (reg_write_enable),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .dmem_ack             (dmem_ack),
    .stall_out            (stall_out),
    .wb_val_out           (wb_val_out),
    .rd_idx_out           (rd_idx_out),
    .reg_write_enable_out (reg_write_enable_out)
`ifdef STAGE4_MEM_ALIGN_CHECK_EN
    ,
    .fault_out            (fault_out)
`endif
  );

  // Free-running clock with period 10; the first falling edge is at t=10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next active (falling) edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present one instruction to the stage.
  task automatic drive(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input logic rwe);
    mem_load_enable  = ld;
    mem_store_enable = st;
    alu_res          = addr;
    rs2_val          = data;
    rd_idx           = rd;
    reg_write_enable = rwe;
  endtask

  // Reset holds every registered output at zero and keeps stall low even with a load presented.
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0104, 32'hAAAA_5555, 5'd3, 1'b1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #3;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    step();
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 66'h0) begin errors++; $display("[TB] FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h expected all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    checks++; if ({wb_val_out, rd_idx_out, reg_write_enable_out} !== 38'h0) begin errors++; $display("[TB] FAIL reset_wb: got wb=%h rd=%0d rwe=%b expected all 0", wb_val_out, rd_idx_out, reg_write_enable_out); end
`ifdef STAGE4_MEM_ALIGN_CHECK_EN
    checks++; if (fault_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fault_out); end
`endif
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_edge: got %b expected 0", stall_out); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    rst_n      = 1'b1;
  endtask

  // Non-memory instructions reach writeback after one edge; an ack in IDLE is ignored.
  task automatic test_passthrough();
    drive(1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd7, 1'b1);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall_pre: got %b expected 0", stall_out); end
    step();
    checks++; if (wb_val_out !== 32'h0000_0055) begin errors++; $display("[TB] FAIL pass_wb: got %h expected 00000055", wb_val_out); end
    checks++; if (rd_idx_out !== 5'd7) begin errors++; $display("[TB] FAIL pass_rd: got %0d expected 7", rd_idx_out); end
    checks++; if (reg_write_enable_out !== 1'b1) begin errors++; $display("[TB] FAIL pass_rwe: got %b expected 1", reg_write_enable_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall: got %b expected 0", stall_out); end
    drive(1'b0, 1'b0, 32'h0000_00A5, 32'h0, 5'd3, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    step();
    checks++; if (wb_val_out !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL pass_ack_ignored_wb: got %h expected 000000a5", wb_val_out); end
    checks++; if (rd_idx_out !== 5'd3) begin errors++; $display("[TB] FAIL pass_rd2: got %0d expected 3", rd_idx_out); end
    checks++; if (reg_write_enable_out !== 1'b0) begin errors++; $display("[TB] FAIL pass_rwe0: got %b expected 0", reg_write_enable_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL pass_no_req: got %b expected 0", dmem_req); end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Zero-wait load: request for one edge, stall for two cycles, one writeback pulse.
  task automatic test_load_zero_wait();
    drive(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd5, 1'b1);
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("[TB] FAIL load_stall_idle: got %b expected 1", stall_out); end
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL load_req: got %b expected 1", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL load_we: got %b expected 0", dmem_we); end
    checks++; if (dmem_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL load_addr: got %h expected 00000100", dmem_addr); end
    checks++; if (reg_write_enable_out !== 1'b0) begin errors++; $display("[TB] FAIL load_bubble: got %b expected 0", reg_write_enable_out); end
    checks++; if (stall_out !== 1'b1) begin errors++; $display("[TB] FAIL load_stall_req: got %b expected 1", stall_out); end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL load_req_drop: got %b expected 0", dmem_req); end
    checks++; if (wb_val_out !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_wb: got %h expected deadbeef", wb_val_out); end
    checks++; if (rd_idx_out !== 5'd5) begin errors++; $display("[TB] FAIL load_rd: got %0d expected 5", rd_idx_out); end
    checks++; if (reg_write_enable_out !== 1'b1) begin errors++; $display("[TB] FAIL load_rwe: got %b expected 1", reg_write_enable_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL load_stall_done: got %b expected 0", stall_out); end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    step();
    checks++; if (reg_write_enable_out !== 1'b0) begin errors++; $display("[TB] FAIL load_rwe_pulse: got %b expected 0", reg_write_enable_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL load_no_reissue: got %b expected 0", dmem_req); end
    checks++; if (wb_val_out !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_wb_hold: got %h expected deadbeef", wb_val_out); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL load_stall_after: got %b expected 0", stall_out); end
  endtask

  // Store with three wait states: request fields stay stable and no writeback ever appears.
  task automatic test_store_wait();
    drive(1'b0, 1'b0, 32'h0BAD_0BAD, 32'h0, 5'd1, 1'b1);
    step();
    drive(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd9, 1'b1);
    step();
    checks++; if ({dmem_req, dmem_we} !== 2'b11) begin errors++; $display("[TB] FAIL store_issue: got req=%b we=%b expected 1 1", dmem_req, dmem_we); end
    checks++; if (reg_write_enable_out !== 1'b0) begin errors++; $display("[TB] FAIL store_bubble: got %b expected 0", reg_write_enable_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 32'h0000_0200, 32'h1234_5678}) begin errors++; $display("[TB] FAIL store_stable_%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000200 12345678", i, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      checks++; if ({stall_out, reg_write_enable_out} !== 2'b10) begin errors++; $display("[TB] FAIL store_wait_%0d: got stall=%b rwe=%b expected 1 0", i, stall_out, reg_write_enable_out); end
    end
    dmem_ack = 1'b1;
    step();
    checks++; if ({dmem_req, reg_write_enable_out, stall_out} !== 3'b000) begin errors++; $display("[TB] FAIL store_ack: got req=%b rwe=%b stall=%b expected 0 0 0", dmem_req, reg_write_enable_out, stall_out); end
    checks++; if (wb_val_out !== 32'h0BAD_0BAD) begin errors++; $display("[TB] FAIL store_wb_hold: got %h expected 0bad0bad", wb_val_out); end
    dmem_ack = 1'b0;
    step();
    checks++; if ({dmem_req, reg_write_enable_out} !== 2'b00) begin errors++; $display("[TB] FAIL store_done: got req=%b rwe=%b expected 0 0", dmem_req, reg_write_enable_out); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Both enables set behaves as a load.
  task automatic test_load_store_both();
    drive(1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 5'd12, 1'b1);
    step();
    checks++; if ({dmem_req, dmem_we} !== 2'b10) begin errors++; $display("[TB] FAIL both_issue: got req=%b we=%b expected 1 0", dmem_req, dmem_we); end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    step();
    checks++; if ({wb_val_out, rd_idx_out, reg_write_enable_out} !== {32'hCAFE_F00D, 5'd12, 1'b1}) begin errors++; $display("[TB] FAIL both_wb: got wb=%h rd=%0d rwe=%b expected cafef00d 12 1", wb_val_out, rd_idx_out, reg_write_enable_out); end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Reset during REQ drops the request at once; a later ack yields no writeback.
  task automatic test_reset_mid_req();
    drive(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd4, 1'b1);
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstreq_issue: got %b expected 1", dmem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({dmem_req, dmem_addr} !== 33'h0) begin errors++; $display("[TB] FAIL rstreq_drop: got req=%b addr=%h expected 0 00000000", dmem_req, dmem_addr); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_stall: got %b expected 0", stall_out); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({dmem_req, reg_write_enable_out, stall_out} !== 3'b000) begin errors++; $display("[TB] FAIL rstreq_first_edge: got req=%b rwe=%b stall=%b expected 0 0 0", dmem_req, reg_write_enable_out, stall_out); end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBADB_AD00;
    step();
    checks++; if ({reg_write_enable_out, wb_val_out} !== 33'h0) begin errors++; $display("[TB] FAIL rstreq_late_ack: got rwe=%b wb=%h expected 0 00000000", reg_write_enable_out, wb_val_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_no_req: got %b expected 0", dmem_req); end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  // Two consecutive loads: exactly two request pulses and two writeback pulses.
  task automatic test_back_to_back();
    int req_pulses = 0;
    int wb_pulses  = 0;
    logic prev_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd1, 1'b1);
        1: begin dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111; end
        2: dmem_ack = 1'b0;
        3: drive(1'b1, 1'b0, 32'h0000_0014, 32'h0, 5'd2, 1'b1);
        4: begin dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222; end
        5: dmem_ack = 1'b0;
        default: drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      endcase
      step();
      if (dmem_req && !prev_req) req_pulses++;
      prev_req = dmem_req;
      if (reg_write_enable_out) wb_pulses++;
      case (i)
        0: begin checks++; if (dmem_addr !== 32'h0000_0010) begin errors++; $display("[TB] FAIL b2b_addr1: got %h expected 00000010", dmem_addr); end end
        1: begin checks++; if ({wb_val_out, rd_idx_out} !== {32'h1111_1111, 5'd1}) begin errors++; $display("[TB] FAIL b2b_wb1: got wb=%h rd=%0d expected 11111111 1", wb_val_out, rd_idx_out); end end
        3: begin checks++; if (dmem_addr !== 32'h0000_0014) begin errors++; $display("[TB] FAIL b2b_addr2: got %h expected 00000014", dmem_addr); end end
        4: begin checks++; if ({wb_val_out, rd_idx_out} !== {32'h2222_2222, 5'd2}) begin errors++; $display("[TB] FAIL b2b_wb2: got wb=%h rd=%0d expected 22222222 2", wb_val_out, rd_idx_out); end end
        default: begin end
      endcase
    end
    dmem_rdata = 32'h0;
    checks++; if (req_pulses !== 2) begin errors++; $display("[TB] FAIL b2b_req_pulses: got %0d expected 2", req_pulses); end
    checks++; if (wb_pulses !== 2) begin errors++; $display("[TB] FAIL b2b_wb_pulses: got %0d expected 2", wb_pulses); end
  endtask

  // Misaligned load: faults without a request when checking is built in, issues as given otherwise.
  task automatic test_align();
    drive(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd6, 1'b1);
`ifdef STAGE4_MEM_ALIGN_CHECK_EN
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL align_stall: got %b expected 0", stall_out); end
    step();
    checks++; if ({fault_out, dmem_req, reg_write_enable_out, stall_out} !== 4'b1000) begin errors++; $display("[TB] FAIL align_fault: got fault=%b req=%b rwe=%b stall=%b expected 1 0 0 0", fault_out, dmem_req, reg_write_enable_out, stall_out); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    checks++; if (fault_out !== 1'b0) begin errors++; $display("[TB] FAIL align_fault_pulse: got %b expected 0", fault_out); end
`else
    step();
    checks++; if ({dmem_req, dmem_addr} !== {1'b1, 32'h0000_0102}) begin errors++; $display("[TB] FAIL align_unchecked: got req=%b addr=%h expected 1 00000102", dmem_req, dmem_addr); end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_0777;
    step();
    checks++; if ({wb_val_out, reg_write_enable_out} !== {32'h0000_0777, 1'b1}) begin errors++; $display("[TB] FAIL align_unchecked_wb: got wb=%h rwe=%b expected 00000777 1", wb_val_out, reg_write_enable_out); end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
`endif
  endtask

  // Run all scenarios in order and report.
  initial begin
    test_reset();
    test_passthrough();
    test_load_zero_wait();
    test_store_wait();
    test_load_store_both();
    test_reset_mid_req();
    test_back_to_back();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
